// File: rtl/vx_tensor_dpu_arbiter.sv
// vx_tensor_dpu_arbiter: round-robin, credit-limited sharing of one in-order tensor DPU with tag-based response routing; TENSOR_ARB_PERF_EN builds perf counters
module vx_tensor_dpu_arbiter #(
  parameter int NUM_REQS        = 4,
  parameter int REQ_DATAW       = 1024,
  parameter int RSP_DATAW       = 512,
  parameter int MAX_OUTSTANDING = 8,
  parameter int REQ_CREDITS     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          dpu_valid_in,
  output logic [REQ_DATAW-1:0]          dpu_data_in,
  input  logic                          dpu_ready_in,
  input  logic                          dpu_valid_out,
  input  logic [RSP_DATAW-1:0]          dpu_data_out,
  output logic                          dpu_ready_out,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [RSP_DATAW-1:0]          rsp_data,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic                          busy,
  output logic [31:0]                   perf_conflicts,
  output logic [31:0]                   perf_credit_st
);
  localparam int IDXW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  localparam int PW   = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW   = $clog2(REQ_CREDITS + 1);

  logic [IDXW-1:0]     rr_ptr, grant, head;
  logic [CW-1:0]       cnt [NUM_REQS];
  logic [IDXW-1:0]     tags [MAX_OUTSTANDING];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [FW-1:0]       fill;
  logic [NUM_REQS-1:0] elig;
  logic                tag_empty, tag_full, issue_fire, rsp_fire;

  assign tag_empty     = fill == '0;
  assign tag_full      = fill == FW'(MAX_OUTSTANDING);
  assign head          = tags[rd_ptr];
  assign dpu_valid_in  = !reset && |elig;
  assign issue_fire    = dpu_valid_in && dpu_ready_in;
  assign dpu_data_in   = req_data[grant*REQ_DATAW +: REQ_DATAW];
  assign dpu_ready_out = !reset && !tag_empty && rsp_ready[head];
  assign rsp_fire      = dpu_valid_out && dpu_ready_out;
  assign rsp_data      = dpu_data_out;
  assign busy          = !tag_empty;

  // eligibility, per-requester ready and response routing
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i]      = req_valid[i] && cnt[i] < CW'(REQ_CREDITS) && !tag_full;
      req_ready[i] = issue_fire && grant == IDXW'(i);
      rsp_valid[i] = !reset && dpu_valid_out && !tag_empty && head == IDXW'(i);
    end
  end

  // round-robin: first eligible index starting at rr_ptr (descending scan so the nearest wins)
  always_comb begin
    grant = rr_ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_REQS]) grant = IDXW'((int'(rr_ptr) + k) % NUM_REQS);
  end

  // tag storage holds no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (issue_fire) tags[wr_ptr] <= grant;
  end

  // tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (issue_fire) wr_ptr <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
      if (rsp_fire) rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
      fill <= fill + FW'(issue_fire) - FW'(rsp_fire);
    end
  end

  // round-robin pointer and per-requester credit counters (issue+response on one requester cancel)
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQS; i++) cnt[i] <= '0;
    end else begin
      if (issue_fire) rr_ptr <= IDXW'((int'(grant) + 1) % NUM_REQS);
      for (int i = 0; i < NUM_REQS; i++)
        cnt[i] <= cnt[i] + CW'(issue_fire && grant == IDXW'(i)) - CW'(rsp_fire && head == IDXW'(i));
    end
  end

  // runtime checks: response with no tag and credit counter wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dpu_valid_out && tag_empty)) else $error("tensor arb tag underflow");
      for (int i = 0; i < NUM_REQS; i++) begin
        assert (!(issue_fire && grant == IDXW'(i) && !(rsp_fire && head == IDXW'(i)) && cnt[i] == CW'(REQ_CREDITS)))
          else $error("tensor arb credit overflow");
        assert (!(rsp_fire && head == IDXW'(i) && !(issue_fire && grant == IDXW'(i)) && cnt[i] == '0))
          else $error("tensor arb credit underflow");
      end
    end
  end

`ifdef TENSOR_ARB_PERF_EN
  logic [31:0] conflicts, credit_st;
  logic        multi, stall;
  // contention and credit-stall detection for this cycle
  always_comb begin
    multi = $countones(elig) > 1;
    stall = 1'b0;
    for (int i = 0; i < NUM_REQS; i++)
      stall = stall | (req_valid[i] && cnt[i] == CW'(REQ_CREDITS) && !tag_full);
  end
  // saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      conflicts <= '0;
      credit_st <= '0;
    end else begin
      if (multi && conflicts != '1) conflicts <= conflicts + 1'b1;
      if (stall && credit_st != '1) credit_st <= credit_st + 1'b1;
    end
  end
  assign perf_conflicts = conflicts;
  assign perf_credit_st = credit_st;
`else
  assign perf_conflicts = '0;
  assign perf_credit_st = '0;
`endif
endmodule
